// File: rtl/rc4_key_search_scheduler_if.sv
// Core-array bus between the RC4 key search scheduler (master) and its
// decryption core + validator pairs (slave).
interface rc4_key_search_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24
);
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic                           core_flush;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_valid;

  modport master (output core_start, core_key, core_flush, input core_done, core_valid);
  modport slave  (input core_start, core_key, core_flush, output core_done, core_valid);
endinterface

// File: rtl/rc4_key_search_scheduler.sv
// Spreads candidate RC4 keys from [key_lo,key_hi] over NUM_CORES cores, stops on the first valid verdict.
// Optional KSS_CYCLE_COUNT_EN adds cycle_count, a saturating count of DISPATCH cycles.
//
// state       | meaning
// IDLE        | no search; after reset or abort
// DISPATCH    | launching keys and collecting verdicts
// FOUND       | a valid key was reported; found_key holds it
// NOT_FOUND   | range exhausted with every core idle
module rc4_key_search_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int KEY_WIDTH   = 24,
  parameter int SEARCH_BITS = 22
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [SEARCH_BITS-1:0]     key_lo,
  input  logic [SEARCH_BITS-1:0]     key_hi,
  rc4_key_search_scheduler_if.master cores,
  output logic                       busy,
  output logic                       found,
  output logic                       not_found,
  output logic [KEY_WIDTH-1:0]       found_key,
  output logic [SEARCH_BITS:0]       keys_tried
`ifdef KSS_CYCLE_COUNT_EN
  ,
  output logic [31:0]                cycle_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_FOUND, S_NOT_FOUND} state_t;
  state_t state_q, state_d;

  // One extra bit so that key_hi = all-ones terminates instead of wrapping.
  logic [SEARCH_BITS:0] next_key_q;
  logic [SEARCH_BITS:0] key_hi_q;
  logic [NUM_CORES-1:0] busy_q;
  logic [NUM_CORES-1:0] start_q;
  logic                 flush_q;
  logic [KEY_WIDTH-1:0] key_q [NUM_CORES];

  logic [NUM_CORES-1:0] live_done;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] launch_oh;
  logic                 exhausted;
  logic                 launch;
  logic [KEY_WIDTH-1:0] win_key;
  logic [SEARCH_BITS:0] done_cnt;

  assign live_done = cores.core_done & busy_q;
  assign hit       = live_done & cores.core_valid;
  assign exhausted = next_key_q > key_hi_q;
  assign launch    = (state_q == S_DISPATCH) && !abort && (hit == '0) && !exhausted
                     && (launch_oh != '0);

  always_comb begin
    launch_oh = '0;
    win_key   = '0;
    done_cnt  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        launch_oh    = '0;
        launch_oh[i] = 1'b1;
      end
      if (hit[i]) win_key = key_q[i];
    end
    for (int i = 0; i < NUM_CORES; i++)
      done_cnt = done_cnt + (SEARCH_BITS + 1)'(live_done[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_DISPATCH: begin
          // A valid verdict wins over exhaustion in the same cycle.
          if (hit != '0)
            state_d = S_FOUND;
          else if (exhausted && ((busy_q & ~cores.core_done) == '0))
            state_d = S_NOT_FOUND;
        end
        default: if (start) state_d = S_DISPATCH;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_DISPATCH);
    found     = (state_q == S_FOUND);
    not_found = (state_q == S_NOT_FOUND);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_key_q <= '0;
      key_hi_q   <= '0;
      busy_q     <= '0;
      start_q    <= '0;
      flush_q    <= 1'b0;
      found_key  <= '0;
      keys_tried <= '0;
      for (int i = 0; i < NUM_CORES; i++) key_q[i] <= '0;
`ifdef KSS_CYCLE_COUNT_EN
      cycle_count <= '0;
`endif
    end else begin
      start_q <= '0;
      flush_q <= 1'b0;
      if (abort) begin
        flush_q <= 1'b1;
        busy_q  <= '0;
      end else if (state_q != S_DISPATCH) begin
        if (start) begin
          next_key_q <= {1'b0, key_lo};
          key_hi_q   <= {1'b0, key_hi};
          keys_tried <= '0;
          found_key  <= '0;
          busy_q     <= '0;
`ifdef KSS_CYCLE_COUNT_EN
          cycle_count <= '0;
`endif
        end
      end else begin
        keys_tried <= keys_tried + done_cnt;
        if (hit != '0) begin
          found_key <= win_key;
          flush_q   <= 1'b1;
          busy_q    <= '0;
        end else begin
          busy_q <= (busy_q & ~cores.core_done) | (launch ? launch_oh : '0);
          if (launch) begin
            start_q    <= launch_oh;
            next_key_q <= next_key_q + (SEARCH_BITS + 1)'(1);
            for (int i = 0; i < NUM_CORES; i++)
              if (launch_oh[i]) key_q[i] <= KEY_WIDTH'(next_key_q[SEARCH_BITS-1:0]);
          end
        end
`ifdef KSS_CYCLE_COUNT_EN
        if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
`endif
      end
    end
  end

  assign cores.core_start = start_q;
  assign cores.core_flush = flush_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_key
    assign cores.core_key[g*KEY_WIDTH +: KEY_WIDTH] = key_q[g];
  end
endmodule
